// File: rtl/ura_arbiter.sv
// Round-robin arbiter and sequencer sharing one URA port between NUM_REQ requesters.
// Define URA_ARB_STATS_EN to add the saturating 16-bit conflict_cnt output.
module ura_arbiter #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int READ_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DEPTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          write_en,
    output logic [DEPTH-1:0]              write_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          read_en,
    output logic [DEPTH-1:0]              read_addr,
    input  logic [DATA_WIDTH-1:0]         read_data,
`ifdef URA_ARB_STATS_EN
    input  logic                          busy,
    output logic [15:0]                   conflict_cnt
`else
    input  logic                          busy
`endif
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [OW-1:0]         ptr;
    logic [OW-1:0]         owner;
    logic [OW-1:0]         winner;
    logic [OW-1:0]         cand;
    logic                  found;
    logic                  we_q;
    logic [DEPTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [1:0]            lat_cnt;
    logic [1:0]            lat_cnt_next;
    logic                  accept;
    logic                  issue_go;
    logic                  rsp_fire;

    // Search starts one past the last winner and wraps, so the last winner ranks lowest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = OW'((int'(ptr) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept   = (state == IDLE) && !busy && found && !rst;
    assign issue_go = (state == ISSUE) && !busy && !rst;
    assign rsp_fire = (state == WAIT_RD) && (lat_cnt == 2'd0) && !rst;

    assign write_en   = issue_go && we_q;
    assign read_en    = issue_go && !we_q;
    assign write_addr = addr_q;
    assign read_addr  = addr_q;
    assign write_data = wdata_q;
    // Response data is shown in the pulse cycle itself and held afterwards.
    assign rsp_data   = rsp_fire ? read_data : rsp_data_q;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
        if (rsp_fire) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!busy) begin
                    if (we_q) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = WAIT_RD;
                        lat_cnt_next = 2'(READ_LAT - 1);
                    end
                end
            end
            WAIT_RD: begin
                if (lat_cnt == 2'd0) begin
                    state_next = IDLE;
                end else begin
                    lat_cnt_next = lat_cnt - 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= OW'(NUM_REQ - 1);
            owner      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            rsp_data_q <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
            if (accept) begin
                ptr     <= winner;
                owner   <= winner;
                we_q    <= req_we[winner];
                addr_q  <= req_addr[winner*DEPTH +: DEPTH];
                wdata_q <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rsp_fire) begin
                rsp_data_q <= read_data;
            end
        end
    end

`ifdef URA_ARB_STATS_EN
    // Counts arbitration cycles where two or more requesters competed.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if ((state == IDLE) && !busy && ($countones(req_valid) >= 2)
                     && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ura_arbiter.sv
// Self-checking bench for ura_arbiter: directed scenarios plus randomized traffic,
// checked by a transaction-level reference model and response scoreboard.
module tb_ura_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int RL    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req_valid = '0;
    logic [NR-1:0]       req_we = '0;
    logic [NR*DEPTH-1:0] req_addr = '0;
    logic [NR*DW-1:0]    req_wdata = '0;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0]       rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                write_en;
    logic [DEPTH-1:0]    write_addr;
    logic [DW-1:0]       write_data;
    logic                read_en;
    logic [DEPTH-1:0]    read_addr;
    logic [DW-1:0]       read_data;
    logic                busy = 1'b0;
`ifdef URA_ARB_STATS_EN
    logic [15:0]         conflict_cnt;
`endif

    ura_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_REQ(NR), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
`ifdef URA_ARB_STATS_EN
        .busy(busy), .conflict_cnt(conflict_cnt)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // URA model: registered memory with a READ_LAT pipeline; junk outside the valid cycle.
    logic [DW-1:0] ura_mem [16] = '{default: '0};
    logic [DW-1:0] rd_pipe [RL];
    logic [RL-1:0] rd_v = '0;
    logic [DW-1:0] junk = '0;

    always @(posedge clk) begin
        if (write_en) ura_mem[write_addr] <= write_data;
        rd_pipe[0] <= ura_mem[read_addr];
        rd_v[0]    <= read_en;
        for (int k = 1; k < RL; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
            rd_v[k]    <= rd_v[k-1];
        end
    end
    assign read_data = rd_v[RL-1] ? rd_pipe[RL-1] : junk;

    // Reference model and scoreboard.
    typedef struct {
        logic             we;
        logic [DEPTH-1:0] addr;
        logic [DW-1:0]    data;
        int               owner;
        int               gcyc;
    } strb_t;
    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    strb_t            sq[$];
    rsp_t             rq[$];
    logic [DW-1:0]    shadow [16] = '{default: '0};
    int               cyc = 0;
    int               ptr_m = NR - 1;
    bit               outstanding = 1'b0;
    logic [DEPTH-1:0] hold_addr = '0;
    logic [DW-1:0]    hold_wdata = '0;
    logic [DW-1:0]    last_rsp = '0;
    int               conf_m = 0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rv;
        logic [1:0]    exp_str;
        int            w;
        strb_t         it;
        rsp_t          r;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_quiet", {req_ready, rsp_valid, write_en, read_en}, '0);
                sq.delete();
                rq.delete();
                outstanding = 1'b0;
                ptr_m       = NR - 1;
                hold_addr   = '0;
                hold_wdata  = '0;
                last_rsp    = '0;
                conf_m      = 0;
            end else begin
                check("addr_hold", {write_addr, read_addr, write_data}, {hold_addr, hold_addr, hold_wdata});
`ifdef URA_ARB_STATS_EN
                check("conflict_cnt", conflict_cnt, conf_m);
                if (!outstanding && !busy && ($countones(req_valid) >= 2) && conf_m < 65535) conf_m++;
`endif
                exp_ready = '0;
                w = -1;
                if (!outstanding && !busy && req_valid != '0) begin
                    w = rr_pick(req_valid, ptr_m);
                    exp_ready[w] = 1'b1;
                end
                check("req_ready", req_ready, exp_ready);
                if (w >= 0) begin
                    ptr_m       = w;
                    outstanding = 1'b1;
                    hold_addr   = req_addr[w*DEPTH +: DEPTH];
                    hold_wdata  = req_wdata[w*DW +: DW];
                    sq.push_back('{req_we[w], hold_addr, hold_wdata, w, cyc});
                end

                exp_str = 2'b00;
                if (sq.size() > 0 && cyc > sq[0].gcyc && !busy) exp_str = sq[0].we ? 2'b10 : 2'b01;
                check("strobe", {write_en, read_en}, exp_str);
                if (exp_str != 2'b00) begin
                    it = sq.pop_front();
                    if (it.we) begin
                        shadow[it.addr] = it.data;
                        outstanding = 1'b0;
                    end else begin
                        rq.push_back('{it.owner, shadow[it.addr], cyc + RL});
                    end
                end

                exp_rv = '0;
                if (rq.size() > 0 && rq[0].due == cyc) exp_rv[rq[0].owner] = 1'b1;
                check("rsp_valid", rsp_valid, exp_rv);
                if (exp_rv != '0) begin
                    r = rq.pop_front();
                    last_rsp    = r.data;
                    outstanding = 1'b0;
                end
                check("rsp_data", rsp_data, last_rsp);
            end
        end
    end

    // Stimulus side: requesters hold a request until accepted, then reload or drop.
    int            remaining [NR] = '{default: 0};
    int            grants[$];
    logic [NR-1:0] snap_ready, snap_rv;
    logic          snap_we, snap_re;
    logic [DEPTH-1:0] snap_waddr, snap_raddr;
    logic [DW-1:0] snap_wdata, snap_rd;

    task automatic load_req(input int i, input logic we, input logic [DEPTH-1:0] addr, input logic [DW-1:0] data);
        req_we[i] = we;
        req_addr[i*DEPTH +: DEPTH] = addr;
        req_wdata[i*DW +: DW] = data;
        req_valid[i] = 1'b1;
    endtask

    task automatic load_rand(input int i);
        load_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
    endtask

    task automatic step();
        @(negedge clk);
        snap_ready = req_ready;  snap_rv    = rsp_valid; snap_rd    = rsp_data;
        snap_we    = write_en;   snap_re    = read_en;
        snap_waddr = write_addr; snap_raddr = read_addr; snap_wdata = write_data;
        @(posedge clk);
        #1;
        junk = 8'($urandom);
        for (int i = 0; i < NR; i++) begin
            if (snap_ready[i]) begin
                grants.push_back(i);
                if (remaining[i] > 0) begin
                    remaining[i]--;
                    load_rand(i);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_grant(input int i, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!snap_ready[i] && n < 20);
        check(name, 32'(snap_ready), 32'(1) << i);
    endtask

    task automatic wait_grants(input int cnt);
        int n = 0;
        while (grants.size() < cnt && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        int alt_exp [6] = '{0, 1, 0, 1, 0, 1};
        int wrap_exp [4] = '{1, 3, 1, 3};

        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_ctrl", {snap_ready, snap_rv, snap_we, snap_re}, '0);
        check("reset_data", {snap_waddr, snap_raddr, snap_wdata, snap_rd}, '0);

        // Write 8'hA5 to address 3 from requester 0.
        load_req(0, 1'b1, 4'd3, 8'hA5);
        wait_grant(0, "wr_grant");
        step();
        check("wr_strobe", {snap_we, snap_re, snap_waddr, snap_wdata}, {2'b10, 4'd3, 8'hA5});
        step();
        check("wr_single", {snap_we, snap_re}, 2'b00);

        // Requester 1 reads it back.
        load_req(1, 1'b0, 4'd3, 8'h00);
        wait_grant(1, "rd_grant");
        step();
        check("rd_strobe", {snap_we, snap_re, snap_raddr}, {2'b01, 4'd3});
        step();
        check("rd_early", 32'(snap_rv), 0);
        step();
        check("rd_rsp", {snap_rv, snap_rd}, {4'b0010, 8'hA5});

        // Two requesters holding valid alternate.
        grants.delete();
        remaining[0] = 2;
        remaining[1] = 2;
        load_rand(0);
        load_rand(1);
        wait_grants(6);
        for (int k = 0; k < 6; k++)
            check("alt_grant", (grants.size() > k) ? grants[k] : -1, alt_exp[k]);
        repeat (20) step();

        // busy blocks acceptance, then delays the strobe.
        busy = 1'b1;
        load_req(0, 1'b1, 4'd5, 8'h5A);
        repeat (3) begin
            step();
            check("busy_no_ready", 32'(snap_ready), 0);
        end
        busy = 1'b0;
        wait_grant(0, "busy_grant");
        busy = 1'b1;
        repeat (2) begin
            step();
            check("busy_no_strobe", {snap_we, snap_re}, 2'b00);
        end
        busy = 1'b0;
        step();
        check("busy_strobe", {snap_we, snap_re, snap_waddr, snap_wdata}, {2'b10, 4'd5, 8'h5A});
        repeat (3) step();

        // Requesters 1 and 3 active: wrap-around order.
        grants.delete();
        remaining[1] = 1;
        remaining[3] = 1;
        load_rand(1);
        load_rand(3);
        wait_grants(4);
        for (int k = 0; k < 4; k++)
            check("wrap_grant", (grants.size() > k) ? grants[k] : -1, wrap_exp[k]);
        repeat (20) step();

        // Reset during a read aborts the response.
        load_req(2, 1'b0, 4'd3, 8'h00);
        wait_grant(2, "abort_grant");
        step();
        check("abort_strobe", {snap_we, snap_re}, 2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) begin
            step();
            check("abort_no_rsp", 32'(snap_rv), 0);
        end

        // Randomized traffic with random busy and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            busy = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                req_valid = '0;
                step();
                rst = 1'b0;
            end else begin
                for (int i = 0; i < NR; i++)
                    if (!req_valid[i] && $urandom_range(0, 2) == 0) load_rand(i);
                step();
            end
        end
        busy = 1'b0;
        wait_grants(grants.size() + $countones(req_valid));
        repeat (20) step();
        check("drain_empty", 32'(sq.size() + rq.size()), 0);
        check("drain_valid", 32'(req_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
